// File: rtl/fibonacci_lfsr.sv
// -----------------------------------------------------------------------------
// fibonacci_lfsr
//
// Purpose:
//   Maximal-length Fibonacci (external-XOR) LFSR with a built-in prescaler.
//   The register advances once every COUNT enabled clock cycles, which lets a
//   fast system clock produce a slowly changing pseudo-random value.
//
// Parameters:
//   WIDTH  register width, 2..16 (other values stop elaboration)
//   COUNT  enabled clock cycles per LFSR step, >= 1 (1 = step every cycle)
//   SEED   reset / reload value of prn, must be non-zero
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   reset        synchronous, active-high reset (dominates everything)
//   lfsr_enable  advance enable; prescaler and LFSR hold while low
//   seed_load    (LFSR_SEED_LOAD_EN only) load `seed` into prn, clear prescaler
//   seed         (LFSR_SEED_LOAD_EN only) value to load; 0 loads SEED instead
//   prn          current LFSR state (registered)
//
// Optional feature macro: LFSR_SEED_LOAD_EN
//   When defined, the seed_load / seed ports exist. When undefined the ports
//   are absent and the block is a plain free-running LFSR.
// -----------------------------------------------------------------------------
module fibonacci_lfsr #(
  parameter int WIDTH = 4,
  parameter int COUNT = 50000000,
  parameter int SEED  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lfsr_enable,
`ifdef LFSR_SEED_LOAD_EN
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
`endif
  output logic [WIDTH-1:0] prn
);

  // ---------------------------------------------------------------------------
  // Parameter checks
  // ---------------------------------------------------------------------------
  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("fibonacci_lfsr: WIDTH must be in the range 2..16");
  end

  if (COUNT < 1) begin : g_bad_count
    $error("fibonacci_lfsr: COUNT must be >= 1");
  end

  if (SEED <= 0 || SEED >= (1 << WIDTH)) begin : g_bad_seed
    $error("fibonacci_lfsr: SEED must be non-zero and fit in WIDTH bits");
  end

  // ---------------------------------------------------------------------------
  // Feedback tap mask. A set bit k means 1-indexed tap (k+1) takes part in the
  // XOR. Each entry is a maximal-length polynomial for that width.
  // ---------------------------------------------------------------------------
  function automatic logic [WIDTH-1:0] tap_mask(input int w);
    logic [15:0] m;
    case (w)
      2:       m = 16'h0003; // 2,1
      3:       m = 16'h0006; // 3,2
      4:       m = 16'h000C; // 4,3
      5:       m = 16'h0014; // 5,3
      6:       m = 16'h0030; // 6,5
      7:       m = 16'h0060; // 7,6
      8:       m = 16'h00B8; // 8,6,5,4
      9:       m = 16'h0110; // 9,5
      10:      m = 16'h0240; // 10,7
      11:      m = 16'h0500; // 11,9
      12:      m = 16'h0829; // 12,6,4,1
      13:      m = 16'h100D; // 13,4,3,1
      14:      m = 16'h2015; // 14,5,3,1
      15:      m = 16'h6000; // 15,14
      16:      m = 16'hD008; // 16,15,13,4
      default: m = 16'h0000;
    endcase
    return m[WIDTH-1:0];
  endfunction

  localparam logic [WIDTH-1:0] TAPS   = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] SEED_V = WIDTH'(SEED);

  // Prescaler is at least one bit wide so COUNT=1 still yields a legal vector.
  localparam int             CW      = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(COUNT - 1);

  // ---------------------------------------------------------------------------
  // Seed-load request, tied off when the feature is compiled out
  // ---------------------------------------------------------------------------
  logic             load_req;
  logic [WIDTH-1:0] load_value;

`ifdef LFSR_SEED_LOAD_EN
  assign load_req   = seed_load;
  // A zero seed would lock the register, so it is replaced by SEED.
  assign load_value = (seed == '0) ? SEED_V : seed;
`else
  assign load_req   = 1'b0;
  assign load_value = SEED_V;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] prn_reg;
  logic [WIDTH-1:0] prn_next;
  logic [CW-1:0]    cnt_reg;
  logic [CW-1:0]    cnt_next;
  logic             fb;
  logic [WIDTH-1:0] shifted;

  assign fb      = ^(prn_reg & TAPS);
  // All-zero is the one state the shift cannot leave (e.g. after an upset),
  // so a step from zero reloads SEED instead.
  assign shifted = (prn_reg == '0) ? SEED_V : {prn_reg[WIDTH-2:0], fb};

  always_comb begin
    prn_next = prn_reg;
    cnt_next = cnt_reg;
    if (load_req) begin
      // Seed load overrides lfsr_enable for this cycle.
      prn_next = load_value;
      cnt_next = '0;
    end else if (lfsr_enable) begin
      if (cnt_reg == CNT_MAX) begin
        cnt_next = '0;
        prn_next = shifted;
      end else begin
        cnt_next = cnt_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prn_reg <= SEED_V;
      cnt_reg <= '0;
    end else begin
      prn_reg <= prn_next;
      cnt_reg <= cnt_next;
    end
  end

  assign prn = prn_reg;

endmodule

// File: tb/tb_fibonacci_lfsr.sv
// -----------------------------------------------------------------------------
// tb_fibonacci_lfsr
//
// Three instances share clock, reset and enable:
//   u_a : WIDTH=4, COUNT=1
//   u_b : WIDTH=4, COUNT=3
//   u_c : WIDTH=8, COUNT=1
// A behavioural model (tap positions as 1-indexed integers, a plain counter of
// enabled edges) predicts every instance; a compare process checks all three
// on every falling edge. Directed literal checks pin the model to the known
// WIDTH=4 sequence and the WIDTH=8 period.
// -----------------------------------------------------------------------------
module tb_fibonacci_lfsr;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] prn_a;
  logic [3:0] prn_b;
  logic [7:0] prn_c;
`ifdef LFSR_SEED_LOAD_EN
  logic       sl;
  logic [3:0] seed4;
  logic [7:0] seed8;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fibonacci_lfsr #(.WIDTH(4), .COUNT(1), .SEED(1)) u_a (
    .clk(clk), .reset(rst), .lfsr_enable(en),
`ifdef LFSR_SEED_LOAD_EN
    .seed_load(sl), .seed(seed4),
`endif
    .prn(prn_a)
  );

  fibonacci_lfsr #(.WIDTH(4), .COUNT(3), .SEED(1)) u_b (
    .clk(clk), .reset(rst), .lfsr_enable(en),
`ifdef LFSR_SEED_LOAD_EN
    .seed_load(sl), .seed(seed4),
`endif
    .prn(prn_b)
  );

  fibonacci_lfsr #(.WIDTH(8), .COUNT(1), .SEED(1)) u_c (
    .clk(clk), .reset(rst), .lfsr_enable(en),
`ifdef LFSR_SEED_LOAD_EN
    .seed_load(sl), .seed(seed8),
`endif
    .prn(prn_c)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  localparam int MW [3] = '{4, 4, 8};
  localparam int MC [3] = '{1, 3, 1};

  int m_prn [3];
  int m_cnt [3];

  function automatic int tapbit(input int s, input int n);
    return (s >> (n - 1)) & 1;
  endfunction

  function automatic int model_step(input int w, input int s);
    int fb;
    fb = 0;
    if (s == 0) return 1;
    case (w)
      4:       fb = tapbit(s, 4) ^ tapbit(s, 3);
      8:       fb = tapbit(s, 8) ^ tapbit(s, 6) ^ tapbit(s, 5) ^ tapbit(s, 4);
      default: fb = 0;
    endcase
    return ((s << 1) | fb) & ((1 << w) - 1);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_prn[i] <= 1;
        m_cnt[i] <= 0;
      end
`ifdef LFSR_SEED_LOAD_EN
      else if (sl) begin
        int sv;
        sv = (MW[i] == 8) ? int'(seed8) : int'(seed4);
        m_prn[i] <= (sv == 0) ? 1 : sv;
        m_cnt[i] <= 0;
      end
`endif
      else if (en) begin
        if (m_cnt[i] + 1 >= MC[i]) begin
          m_cnt[i] <= 0;
          m_prn[i] <= model_step(MW[i], m_prn[i]);
        end else begin
          m_cnt[i] <= m_cnt[i] + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_on) begin
      check("model_a", {28'd0, prn_a}, m_prn[0]);
      check("model_b", {28'd0, prn_b}, m_prn[1]);
      check("model_c", {24'd0, prn_c}, m_prn[2]);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus and directed literal checks (inputs change on falling edges)
  // ---------------------------------------------------------------------------
  int seq_a [16] = '{2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8, 1, 2};

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    en  = 1'b0;
`ifdef LFSR_SEED_LOAD_EN
    sl    = 1'b0;
    seed4 = '0;
    seed8 = '0;
`endif

    // Reset held for 5 clocks with enable toggling
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("reset_prn_a", {28'd0, prn_a}, 32'd1);
      check("reset_prn_c", {24'd0, prn_c}, 32'd1);
      en = ~en;
    end
    cmp_on = 1'b1;

    // Full sequence, COUNT=1; prescaler COUNT=3 in parallel
    rst = 1'b0;
    en  = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("seq_a", {28'd0, prn_a}, seq_a[k]);
      if (k == 1) check("presc_hold", {28'd0, prn_b}, 32'd1);
      if (k == 2) check("presc_step1", {28'd0, prn_b}, 32'd2);
      if (k == 5) check("presc_step2", {28'd0, prn_b}, 32'd4);
    end

    // Enable gating: 5 high, 5 low, 5 high
    en = 1'b0;
    do_reset();
    en = 1'b1;
    repeat (5) @(negedge clk);
    check("gate_high1", {28'd0, prn_a}, 32'd6);
    en = 1'b0;
    repeat (5) @(negedge clk);
    check("gate_low", {28'd0, prn_a}, 32'd6);
    en = 1'b1;
    repeat (5) @(negedge clk);
    check("gate_high2", {28'd0, prn_a}, 32'd7);

    // Prescaler count is held (not cleared) while enable is low
    en = 1'b0;
    do_reset();
    en = 1'b1;
    repeat (2) @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    check("presc_held", {28'd0, prn_b}, 32'd1);
    en = 1'b1;
    @(negedge clk);
    check("presc_resume", {28'd0, prn_b}, 32'd2);

    // Mid-operation reset
    do_reset();
    en = 1'b1;
    repeat (7) @(negedge clk);
    check("mid_before", {28'd0, prn_a}, 32'd10);
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset", {28'd0, prn_a}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_restart", {28'd0, prn_a}, 32'd2);

    // WIDTH=8 period: back to 1 after exactly 255 enabled edges
    en = 1'b0;
    do_reset();
    en = 1'b1;
    n = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (prn_c == 8'd1) begin
        n = k;
        break;
      end
    end
    check("period_w8", n, 32'd255);

`ifdef LFSR_SEED_LOAD_EN
    // Seed load: zero seed falls back to SEED, non-zero seed is loaded as-is
    en    = 1'b1;
    sl    = 1'b1;
    seed4 = 4'd0;
    seed8 = 8'd0;
    @(negedge clk);
    check("seed_zero_a", {28'd0, prn_a}, 32'd1);
    seed4 = 4'd9;
    seed8 = 8'd9;
    @(negedge clk);
    check("seed_nine_a", {28'd0, prn_a}, 32'd9);
    check("seed_nine_c", {24'd0, prn_c}, 32'd9);
    sl = 1'b0;
    @(negedge clk);
    check("seed_step_a", {28'd0, prn_a}, 32'd3);
`endif

    // Randomized run, checked every cycle by the model
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      en  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
`ifdef LFSR_SEED_LOAD_EN
      sl    = ($urandom_range(0, 99) == 0);
      seed4 = 4'($urandom_range(0, 15));
      seed8 = 8'($urandom_range(0, 255));
`endif
    end
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
`ifdef LFSR_SEED_LOAD_EN
    sl = 1'b0;
`endif
    @(negedge clk);
    @(posedge clk);
    cmp_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fibonacci_lfsr.md
Name: fibonacci_lfsr

Overview:
- Parameterised Fibonacci (external-XOR) linear feedback shift register producing a maximal-length pseudo-random number on `prn`.
- A built-in prescaler advances the register once every COUNT enabled clock cycles, so slow visible sequences can be generated from a fast system clock.
- Used as a free-running PRN source gated by `lfsr_enable`.

Parameters:
- WIDTH, 4, register width in bits; supported range 2..16; any other value is an elaboration error.
- COUNT, 50000000, enabled clock cycles per LFSR step; must be >= 1; COUNT=1 steps on every enabled cycle.
- SEED, 1, reset/reload value of `prn`; must be non-zero, otherwise an elaboration error.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- lfsr_enable  input  1  advance enable; prescaler and LFSR only progress while high.
- prn  output  WIDTH  current LFSR state (registered).

Behaviour:
- Single clock domain `clk`. Reset is synchronous and active-high.
- Reset dominates all other inputs.
  - On a rising edge with reset=1: prn <= SEED, prescaler <= 0.
- Prescaler: counter of width max(1, clog2(COUNT)).
  - When lfsr_enable=1 and the counter equals COUNT-1: the counter wraps to 0 and the LFSR steps once.
  - When lfsr_enable=1 and the counter is below COUNT-1: the counter increments and prn holds.
  - When lfsr_enable=0: counter and prn both hold; the counter is not cleared.
- The first step occurs on the COUNT-th enabled rising edge after reset.
- Step rule: prn <= {prn[WIDTH-2:0], fb}, i.e. shift left with feedback into the LSB.
  - fb = XOR of the tap bits (1-indexed bit n = prn[n-1]).
- Tap table, maximal-length:
  - 2:(2,1) 3:(3,2) 4:(4,3) 5:(5,3) 6:(6,5) 7:(7,6) 8:(8,6,5,4)
  - 9:(9,5) 10:(10,7) 11:(11,9) 12:(12,6,4,1) 13:(13,4,3,1) 14:(14,5,3,1)
  - 15:(15,14) 16:(16,15,13,4)
- Period is 2^WIDTH-1 steps. The all-zero state is never produced.
- Lockup guard: if prn is ever 0 (e.g. SEU), the next step loads SEED instead of shifting.
- WIDTH=4, SEED=1 step sequence in decimal: 1,2,4,9,3,6,13,10,5,11,7,15,14,12,8, then back to 1.
- Reset asserted mid-count discards the partial prescaler count.
- `prn` changes only on rising clk edges; no combinational path from inputs to `prn`.

Optional Feature:
- Macro: LFSR_SEED_LOAD_EN.
- When defined, two extra ports are added: `seed_load` (input, 1) and `seed` (input, WIDTH).
- With seed_load=1 and reset=0 on a rising edge:
  - prn <= seed, prescaler <= 0; lfsr_enable is ignored that cycle.
  - If seed==0, SEED is loaded instead.
- Reset has priority over seed_load.
- When the macro is undefined, the ports do not exist and behaviour is exactly as above.

Test Plan:
- Reset: WIDTH=4, COUNT=1, hold reset=1 for 5 clocks with lfsr_enable toggling -> prn=1 throughout. Counter 0 after release.
- Full sequence: COUNT=1, release reset, lfsr_enable=1 for 16 clocks -> prn = 2,4,9,3,6,13,10,5,11,7,15,14,12,8,1,2. Never 0; no value repeats within 15 steps.
- Enable gating: COUNT=1, lfsr_enable toggled every 5 clocks (TB pattern with a 10 ns clock and 50 ns toggles) -> prn advances exactly 5 steps per high window and holds constant during low windows.
- Prescaler: COUNT=3, lfsr_enable=1 -> prn steps 1->2 on the 3rd enabled edge and 2->4 on the 6th. Drop enable after 2 edges, raise it later -> the step occurs after 1 more enabled edge (count held).
- Mid-operation reset: COUNT=1, run 7 steps (prn=10), assert reset for 1 clock -> prn=1 next edge; sequence restarts at 2.
- Period check: WIDTH=8, COUNT=1, SEED=1 -> prn returns to 1 after exactly 255 enabled edges, and not before. With LFSR_SEED_LOAD_EN, seed_load with seed=0 -> prn=1; with seed=9 -> prn=9, next step 3.
